// File: rtl/rvfi_sched_pkg.sv
// Shared types and helpers for the RVFI CSR-write check sequencer.
// Holds the FSM state encoding, CSR/opcode constants and a retire popcount.
package rvfi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_ARMED,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [11:0] CSR_NONE   = 12'hFFF;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam int          MAX_NRET   = 64;

    function automatic logic [15:0] popcount(input logic [MAX_NRET-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < MAX_NRET; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_csr_match.sv
// Per-channel CSR instruction decoder: flags a retired CSR op hitting a target index.
// Purely combinational, zero latency; no flow control.
module rvfi_csr_match
    import rvfi_sched_pkg::*;
#(
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] insn,
    input  logic            valid,
    input  logic [11:0]     csr_maddr,
    input  logic [11:0]     csr_saddr,
    input  logic [11:0]     csr_uaddr,
    output logic            match
);

    logic [11:0] addr;
    logic        hi_zero;
    logic        unused_fields;

    assign addr          = insn[31:20];
    assign unused_fields = ^{insn[19:14], insn[11:7]};

    // Compressed/wide encodings must not alias onto a 32-bit CSR op.
    generate
        if (ILEN > 32) begin : g_wide
            assign hi_zero = ~|insn[ILEN-1:32];
        end else begin : g_narrow
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign match = valid
                && (insn[6:0] == OPC_SYSTEM)
                && (insn[13:12] != 2'b00)
                && hi_zero
                && (addr != CSR_NONE)
                && ((addr == csr_maddr) || (addr == csr_saddr) || (addr == csr_uaddr));

endmodule

// File: rtl/rvfi_csrw_sched.sv
// Sequencer that skips SKIP retirements, then strobes check for the first matching CSR op.
// Match at cycle t gives check at t+1 and done from t+2; no backpressure, inputs are never stalled.
module rvfi_csrw_sched
    import rvfi_sched_pkg::*;
#(
    parameter int NRET    = 1,
    parameter int ILEN    = 32,
    parameter int SKIP    = 0,
    parameter int TIMEOUT = 64
) (
    input  logic                                      clock,
    input  logic                                      resetn,
    input  logic                                      enable,
    input  logic [11:0]                               csr_maddr,
    input  logic [11:0]                               csr_saddr,
    input  logic [11:0]                               csr_uaddr,
    input  logic [NRET-1:0]                           rvfi_valid,
    input  logic [NRET*ILEN-1:0]                      rvfi_insn,
    input  logic [NRET*64-1:0]                        rvfi_order,
    output logic                                      check,
    output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] check_chan,
    output logic [ILEN-1:0]                           check_insn,
    output logic [63:0]                               check_order,
    output logic                                      done,
    output logic                                      timeout,
    output logic [15:0]                               retired
);

    localparam int          CW       = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] SKIP_W   = 16'(SKIP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [NRET-1:0]     hit;
    logic                any_hit;
    logic [CW-1:0]       hit_chan;
    logic [MAX_NRET-1:0] valid_ext;
    logic [16:0]         ret_sum;
    logic [15:0]         retired_nxt;
    logic [TW-1:0]       tmo_cnt;

    for (genvar k = 0; k < NRET; k++) begin : g_match
        rvfi_csr_match #(.ILEN(ILEN)) u_match (
            .insn      (rvfi_insn[k*ILEN +: ILEN]),
            .valid     (rvfi_valid[k]),
            .csr_maddr (csr_maddr),
            .csr_saddr (csr_saddr),
            .csr_uaddr (csr_uaddr),
            .match     (hit[k])
        );
    end

    assign any_hit = |hit;

    // Lowest channel wins: it retires first in program order.
    always_comb begin
        hit_chan = '0;
        for (int k = NRET - 1; k >= 0; k--) begin
            if (hit[k]) hit_chan = CW'(k);
        end
    end

    always_comb begin
        valid_ext             = '0;
        valid_ext[NRET-1:0]   = rvfi_valid;
        ret_sum               = {1'b0, retired} + {1'b0, popcount(valid_ext)};
        retired_nxt           = ret_sum[16] ? 16'hFFFF : ret_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (enable) state_nxt = (SKIP == 0) ? ST_ARMED : ST_SKIP;
            ST_SKIP:  if (retired_nxt >= SKIP_W) state_nxt = ST_ARMED;
            ST_ARMED: begin
                // A match in the expiry cycle takes priority over giving up.
                if (any_hit)                   state_nxt = ST_CHECK;
                else if (tmo_cnt == TMO_LAST)  state_nxt = ST_FAIL;
            end
            ST_CHECK: state_nxt = ST_DONE;
            default:  state_nxt = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            retired     <= '0;
            tmo_cnt     <= '0;
            check_chan  <= '0;
            check_insn  <= '0;
            check_order <= '0;
        end else begin
            if (state == ST_SKIP || state == ST_ARMED) retired <= retired_nxt;
            if (state == ST_ARMED && !any_hit)         tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_ARMED && any_hit) begin
                check_chan  <= hit_chan;
                check_insn  <= rvfi_insn[hit_chan*ILEN +: ILEN];
                check_order <= rvfi_order[hit_chan*64 +: 64];
            end
        end
    end

    assign check   = (state == ST_CHECK);
    assign done    = (state == ST_DONE);
    assign timeout = (state == ST_FAIL);

endmodule

// File: tb/tb_rvfi_csrw_sched.sv
// Bench for rvfi_csrw_sched: directed scenarios plus randomized retire streams vs a reference model.
// DUT A: NRET=1 SKIP=0 TIMEOUT=8; DUT B: NRET=2 SKIP=3 TIMEOUT=16, both fed the same channel-0 stream.
module tb_rvfi_csrw_sched;

    localparam logic [31:0] I_CSRRW_B00 = 32'hB00110F3;
    localparam logic [31:0] I_ADDI      = 32'h00100093;
    localparam logic [31:0] I_CSRRS_301 = 32'h301020F3;
    localparam logic [31:0] I_ECALL_301 = 32'h30100073;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn, enable;
    logic [11:0] csr_maddr, csr_saddr, csr_uaddr;

    logic [0:0]   a_valid;  logic [31:0] a_insn;  logic [63:0]  a_order;
    logic         a_check;  logic [0:0]  a_chan;  logic [31:0]  a_cinsn;
    logic [63:0]  a_corder; logic        a_done;  logic         a_tmo;  logic [15:0] a_ret;
    logic [1:0]   b_valid;  logic [63:0] b_insn;  logic [127:0] b_order;
    logic         b_check;  logic [0:0]  b_chan;  logic [31:0]  b_cinsn;
    logic [63:0]  b_corder; logic        b_done;  logic         b_tmo;  logic [15:0] b_ret;

    rvfi_csrw_sched #(.NRET(1), .ILEN(32), .SKIP(0), .TIMEOUT(8)) u_dut_a (
        .clock(clock), .resetn(resetn), .enable(enable),
        .csr_maddr(csr_maddr), .csr_saddr(csr_saddr), .csr_uaddr(csr_uaddr),
        .rvfi_valid(a_valid), .rvfi_insn(a_insn), .rvfi_order(a_order),
        .check(a_check), .check_chan(a_chan), .check_insn(a_cinsn), .check_order(a_corder),
        .done(a_done), .timeout(a_tmo), .retired(a_ret));

    rvfi_csrw_sched #(.NRET(2), .ILEN(32), .SKIP(3), .TIMEOUT(16)) u_dut_b (
        .clock(clock), .resetn(resetn), .enable(enable),
        .csr_maddr(csr_maddr), .csr_saddr(csr_saddr), .csr_uaddr(csr_uaddr),
        .rvfi_valid(b_valid), .rvfi_insn(b_insn), .rvfi_order(b_order),
        .check(b_check), .check_chan(b_chan), .check_insn(b_cinsn), .check_order(b_corder),
        .done(b_done), .timeout(b_tmo), .retired(b_ret));

    // Per-cycle stimulus: index j is presented during cycle j+1 (cycle 0 carries enable).
    logic [1:0]  st_valid [80];
    logic [31:0] st_insn  [80][2];
    logic [63:0] st_order [80][2];

    int checks = 0;
    int errors = 0;

    int exp_kind, exp_cyc, exp_chan, exp_ret;
    logic [31:0] exp_insn;
    logic [63:0] exp_order;

    int obs_check_cnt, obs_check_cyc, obs_done_cyc, obs_tmo_cyc, obs_chan, obs_ret;
    logic [31:0] obs_insn;
    logic [63:0] obs_order;
    bit obs_cap_nz, obs_hold_bad, obs_post_rst, rst_fired;

    function automatic logic [31:0] csr_insn(input logic [11:0] addr, input logic [2:0] f3);
        return {addr, 5'd2, f3, 5'd1, 7'b1110011};
    endfunction

    // A retired instruction is a CSR op when it is SYSTEM with a nonzero low funct3,
    // and it is of interest when its real (non-FFF) address is one of the targets.
    function automatic bit ref_match(input logic [31:0] i);
        logic [11:0] a;
        a = i[31:20];
        if (i[6:0] != 7'b1110011 || i[13:12] == 2'b00) return 0;
        if (a == 12'hFFF) return 0;
        return (a == csr_maddr) || (a == csr_saddr) || (a == csr_uaddr);
    endfunction

    task automatic clear_stim();
        for (int j = 0; j < 80; j++) begin
            st_valid[j] = '0;
            for (int k = 0; k < 2; k++) begin
                st_insn[j][k]  = '0;
                st_order[j][k] = '0;
            end
        end
    endtask

    task automatic drive(input int j);
        a_valid = st_valid[j][0];
        a_insn  = st_insn[j][0];
        a_order = st_order[j][0];
        b_valid = st_valid[j];
        b_insn  = {st_insn[j][1], st_insn[j][0]};
        b_order = {st_order[j][1], st_order[j][0]};
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        enable = 1'b0;
        drive(79);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Walks the stream as the sequencer's rules describe: skip phase, then armed window.
    task automatic model(input int sel, input int ncyc);
        int nret, skip, tmo, cnt, acyc, pop, first;
        bit armed;
        nret = sel ? 2 : 1;  skip = sel ? 3 : 0;  tmo = sel ? 16 : 8;
        cnt = 0; acyc = 0; armed = (skip == 0);
        exp_kind = 0; exp_cyc = -1; exp_chan = 0; exp_ret = 0; exp_insn = '0; exp_order = '0;
        for (int j = 0; j < ncyc + 3; j++) begin
            pop = 0; first = -1;
            for (int k = 0; k < nret; k++) begin
                if (st_valid[j][k]) begin
                    pop++;
                    if (armed && first < 0 && ref_match(st_insn[j][k])) first = k;
                end
            end
            cnt = (cnt + pop > 65535) ? 65535 : cnt + pop;
            if (!armed) begin
                armed = (cnt >= skip);
            end else if (first >= 0) begin
                exp_kind = 1; exp_cyc = j + 2; exp_chan = first; exp_ret = cnt;
                exp_insn = st_insn[j][first]; exp_order = st_order[j][first];
                return;
            end else begin
                acyc++;
                if (acyc == tmo) begin
                    exp_kind = 2; exp_cyc = j + 2; exp_ret = cnt;
                    return;
                end
            end
        end
    endtask

    // Runs one enable-to-outcome session on the selected DUT and records what it did.
    task automatic run_case(input int sel, input int ncyc, input bit do_reset,
                            input bit jitter, input bit rst_at_check);
        logic o_check, o_done, o_tmo;
        logic [0:0] o_chan;
        logic [31:0] o_insn;
        logic [63:0] o_order;
        logic [15:0] o_ret;
        bit rst_pend;
        rst_pend = 0;
        if (do_reset) apply_reset();
        obs_check_cnt = 0; obs_check_cyc = -1; obs_done_cyc = -1; obs_tmo_cyc = -1;
        obs_chan = 0; obs_ret = 0; obs_insn = '0; obs_order = '0;
        obs_cap_nz = 0; obs_hold_bad = 0; obs_post_rst = 0; rst_fired = 0;
        @(negedge clock);
        enable = 1'b1;
        drive(79);
        for (int c = 1; c <= ncyc + 4; c++) begin
            @(negedge clock);
            enable  = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
            o_check = sel ? b_check  : a_check;
            o_done  = sel ? b_done   : a_done;
            o_tmo   = sel ? b_tmo    : a_tmo;
            o_chan  = sel ? b_chan   : a_chan;
            o_insn  = sel ? b_cinsn  : a_cinsn;
            o_order = sel ? b_corder : a_corder;
            o_ret   = sel ? b_ret    : a_ret;
            if (rst_pend) begin
                obs_post_rst = o_check | o_done | o_tmo | (|o_chan) | (|o_insn) | (|o_order) | (|o_ret);
                resetn = 1'b1;
                rst_pend = 0;
            end else begin
                if (o_check) begin
                    obs_check_cnt++;
                    if (obs_check_cyc < 0) begin
                        obs_check_cyc = c; obs_chan = int'(o_chan); obs_insn = o_insn;
                        obs_order = o_order; obs_ret = int'(o_ret);
                    end
                    if (rst_at_check && !rst_fired) begin
                        resetn = 1'b0; rst_fired = 1; rst_pend = 1;
                    end
                end
                if (o_done && obs_done_cyc < 0) obs_done_cyc = c;
                if (o_tmo && obs_tmo_cyc < 0) obs_tmo_cyc = c;
                if (o_tmo && ((|o_chan) || (|o_insn) || (|o_order))) obs_cap_nz = 1;
                if (o_done && (o_insn !== obs_insn || o_order !== obs_order || int'(o_chan) != obs_chan))
                    obs_hold_bad = 1;
            end
            drive(c - 1);
        end
        enable = 1'b0;
        drive(79);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if ({a_check, a_done, a_tmo} !== 3'b000) begin errors++;
            $display("FAIL reset_a_flags: got %b expected 000", {a_check, a_done, a_tmo}); end
        checks++; if ({b_check, b_done, b_tmo} !== 3'b000) begin errors++;
            $display("FAIL reset_b_flags: got %b expected 000", {b_check, b_done, b_tmo}); end
        checks++; if (a_ret !== 16'd0 || b_ret !== 16'd0) begin errors++;
            $display("FAIL reset_retired: got %0d/%0d expected 0/0", a_ret, b_ret); end
        checks++; if (a_cinsn !== 32'd0 || a_corder !== 64'd0 || a_chan !== 1'b0) begin errors++;
            $display("FAIL reset_capture: got insn %h order %h expected 0", a_cinsn, a_corder); end
    endtask

    task automatic test_basic();
        csr_maddr = 12'hB00; csr_saddr = 12'hFFF; csr_uaddr = 12'hC00;
        clear_stim();
        st_valid[2][0] = 1'b1; st_insn[2][0] = I_CSRRW_B00; st_order[2][0] = 64'd7;
        model(0, 6);
        run_case(0, 6, 1, 0, 0);
        checks++; if (obs_check_cyc !== 4 || exp_cyc !== 4) begin errors++;
            $display("FAIL basic_check_cycle: got %0d model %0d expected 4", obs_check_cyc, exp_cyc); end
        checks++; if (obs_insn !== 32'hB00110F3) begin errors++;
            $display("FAIL basic_insn: got %h expected b00110f3", obs_insn); end
        checks++; if (obs_chan !== 0 || obs_order !== 64'd7) begin errors++;
            $display("FAIL basic_chan_order: got %0d/%0d expected 0/7", obs_chan, obs_order); end
        checks++; if (obs_done_cyc !== 5) begin errors++;
            $display("FAIL basic_done_cycle: got %0d expected 5", obs_done_cyc); end
        checks++; if (obs_check_cnt !== 1 || obs_hold_bad) begin errors++;
            $display("FAIL basic_strobe: got %0d pulses hold_bad %0d expected 1/0", obs_check_cnt, obs_hold_bad); end
    endtask

    task automatic test_skip();
        csr_maddr = 12'hB00; csr_saddr = 12'hFFF; csr_uaddr = 12'hC00;
        clear_stim();
        for (int j = 0; j < 4; j++) begin
            st_valid[j][0] = 1'b1; st_insn[j][0] = I_CSRRW_B00; st_order[j][0] = 64'(j + 1);
        end
        model(1, 6);
        run_case(1, 6, 1, 0, 0);
        checks++; if (obs_check_cyc !== exp_cyc || obs_check_cyc !== 5) begin errors++;
            $display("FAIL skip_check_cycle: got %0d expected 5", obs_check_cyc); end
        checks++; if (obs_ret !== 4) begin errors++;
            $display("FAIL skip_retired: got %0d expected 4", obs_ret); end
        checks++; if (obs_order !== 64'd4) begin errors++;
            $display("FAIL skip_captured_order: got %0d expected 4", obs_order); end
    endtask

    task automatic test_dual_channel();
        csr_maddr = 12'hB00; csr_saddr = 12'hFFF; csr_uaddr = 12'hC00;
        for (int v = 0; v < 2; v++) begin
            clear_stim();
            for (int j = 0; j < 3; j++) begin st_valid[j][0] = 1'b1; st_insn[j][0] = I_ADDI; end
            st_valid[3] = 2'b11;
            st_insn[3][0] = (v == 0) ? I_CSRRW_B00 : I_ADDI; st_order[3][0] = 64'd10;
            st_insn[3][1] = I_CSRRW_B00;                    st_order[3][1] = 64'd11;
            model(1, 6);
            run_case(1, 6, 1, 0, 0);
            checks++; if (obs_chan !== v || obs_chan !== exp_chan) begin errors++;
                $display("FAIL dual_chan_%0d: got %0d expected %0d", v, obs_chan, v); end
            checks++; if (obs_order !== 64'(10 + v) || obs_check_cyc !== exp_cyc) begin errors++;
                $display("FAIL dual_order_%0d: got %0d at %0d expected %0d at %0d",
                         v, obs_order, obs_check_cyc, 10 + v, exp_cyc); end
        end
    endtask

    task automatic test_timeout();
        csr_maddr = 12'hB00; csr_saddr = 12'hFFF; csr_uaddr = 12'hC00;
        clear_stim();
        for (int j = 0; j < 12; j++) begin st_valid[j][0] = 1'b1; st_insn[j][0] = I_ADDI; end
        model(0, 12);
        run_case(0, 12, 1, 0, 0);
        checks++; if (obs_tmo_cyc !== 9 || exp_cyc !== 9) begin errors++;
            $display("FAIL timeout_cycle: got %0d model %0d expected 9", obs_tmo_cyc, exp_cyc); end
        checks++; if (obs_check_cnt !== 0 || obs_done_cyc !== -1) begin errors++;
            $display("FAIL timeout_no_check: got %0d pulses done at %0d expected none", obs_check_cnt, obs_done_cyc); end
        checks++; if (obs_cap_nz) begin errors++;
            $display("FAIL timeout_capture_zero: got nonzero expected zero"); end
    endtask

    task automatic test_misa();
        csr_maddr = 12'h301; csr_saddr = 12'hFFF; csr_uaddr = 12'hFFF;
        clear_stim();
        st_valid[1][0] = 1'b1; st_insn[1][0] = I_CSRRS_301;
        run_case(0, 6, 1, 0, 0);
        checks++; if (obs_check_cyc !== 3 || obs_insn !== I_CSRRS_301) begin errors++;
            $display("FAIL misa_match: got cycle %0d insn %h expected 3/%h", obs_check_cyc, obs_insn, I_CSRRS_301); end
        st_insn[1][0] = I_ECALL_301;
        run_case(0, 12, 1, 0, 0);
        checks++; if (obs_check_cnt !== 0 || obs_tmo_cyc !== 9) begin errors++;
            $display("FAIL misa_funct3_zero: got %0d pulses timeout at %0d expected 0/9", obs_check_cnt, obs_tmo_cyc); end
    endtask

    task automatic test_reset_in_check();
        csr_maddr = 12'hB00; csr_saddr = 12'hFFF; csr_uaddr = 12'hC00;
        clear_stim();
        st_valid[2][0] = 1'b1; st_insn[2][0] = I_CSRRW_B00; st_order[2][0] = 64'd21;
        run_case(0, 6, 1, 0, 1);
        checks++; if (!rst_fired || obs_post_rst) begin errors++;
            $display("FAIL rst_in_check: got fired %0d outputs_nonzero %0d expected 1/0", rst_fired, obs_post_rst); end
        run_case(0, 6, 0, 0, 0);
        checks++; if (obs_check_cyc !== 4 || obs_order !== 64'd21 || obs_done_cyc !== 5) begin errors++;
            $display("FAIL rst_recheck: got cycle %0d order %0d done %0d expected 4/21/5",
                     obs_check_cyc, obs_order, obs_done_cyc); end
    endtask

    task automatic test_random();
        int sel, ncyc;
        logic [11:0] pick_addr;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 1);
            ncyc = $urandom_range(4, 24);
            csr_maddr = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            csr_saddr = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
            csr_uaddr = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
            clear_stim();
            for (int j = 0; j < ncyc; j++) begin
                for (int k = 0; k < 2; k++) begin
                    st_valid[j][k] = ($urandom_range(0, 2) == 0);
                    st_order[j][k] = {$urandom, $urandom};
                    pick_addr = ($urandom_range(0, 2) == 0) ? csr_maddr :
                                ($urandom_range(0, 1) == 0) ? csr_saddr : csr_uaddr;
                    case ($urandom_range(0, 6))
                        0, 1: st_insn[j][k] = csr_insn(pick_addr, {1'($urandom), 2'($urandom_range(1, 3))});
                        2:    st_insn[j][k] = csr_insn(12'hFFF, 3'b001);
                        3:    st_insn[j][k] = csr_insn(pick_addr, {1'($urandom), 2'b00});
                        4:    st_insn[j][k] = I_ADDI;
                        default: st_insn[j][k] = $urandom;
                    endcase
                end
            end
            model(sel, ncyc);
            run_case(sel, ncyc, 1, 1, 0);
            if (exp_kind == 1) begin
                checks++; if (obs_check_cyc !== exp_cyc || obs_check_cnt !== 1 || obs_done_cyc !== exp_cyc + 1) begin errors++;
                    $display("FAIL rand%0d_timing: got check %0d x%0d done %0d expected %0d x1 done %0d",
                             it, obs_check_cyc, obs_check_cnt, obs_done_cyc, exp_cyc, exp_cyc + 1); end
                checks++; if (obs_chan !== exp_chan || obs_insn !== exp_insn || obs_order !== exp_order) begin errors++;
                    $display("FAIL rand%0d_capture: got %0d/%h/%h expected %0d/%h/%h",
                             it, obs_chan, obs_insn, obs_order, exp_chan, exp_insn, exp_order); end
                checks++; if (obs_ret !== exp_ret || obs_hold_bad) begin errors++;
                    $display("FAIL rand%0d_retired: got %0d hold_bad %0d expected %0d/0", it, obs_ret, obs_hold_bad, exp_ret); end
            end else if (exp_kind == 2) begin
                checks++; if (obs_tmo_cyc !== exp_cyc || obs_check_cnt !== 0 || obs_cap_nz) begin errors++;
                    $display("FAIL rand%0d_timeout: got %0d x%0d cap_nz %0d expected %0d x0 0",
                             it, obs_tmo_cyc, obs_check_cnt, obs_cap_nz, exp_cyc); end
            end else begin
                checks++; if (obs_check_cnt !== 0 || obs_tmo_cyc !== -1) begin errors++;
                    $display("FAIL rand%0d_idle: got %0d pulses timeout %0d expected none", it, obs_check_cnt, obs_tmo_cyc); end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0;
        csr_maddr = 12'hFFF; csr_saddr = 12'hFFF; csr_uaddr = 12'hFFF;
        clear_stim();
        drive(79);
        test_reset();
        test_basic();
        test_skip();
        test_dual_channel();
        test_timeout();
        test_misa();
        test_reset_in_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
